timestep_sequencer: RTL

TIMESTEP_SEQUENCER -- requirements
Module: timestep_sequencer

---
 rtl/snn_timing_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 28 ++
 rtl/timestep_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/snn_timing_pkg.sv
// rtl/snn_timing_pkg.sv - shared state type and default sizing for the timestep sequencer
package snn_timing_pkg;

  localparam int DEF_NUM_STEPS   = 16;
  localparam int DEF_STEP_W      = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    TS_IDLE,
    TS_RUN,
    TS_DRAIN,
    TS_DONE
  } ts_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer plus one-cycle rising-edge pulse
module sync_edge_detect
  import snn_timing_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/timestep_sequencer.sv
// rtl/timestep_sequencer.sv - paces inference timesteps from a slow clock, with busy back-pressure
module timestep_sequencer
  import snn_timing_pkg::*;
#(
  parameter int NUM_STEPS   = DEF_NUM_STEPS,
  parameter int STEP_W      = DEF_STEP_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              clk_slow,
  input  logic              start,
  input  logic              abort,
  input  logic              net_busy,
  output logic              step_tick,
  output logic [STEP_W-1:0] step_idx,
  output logic              running,
  output logic              done,
  output logic              overrun
);

  localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_STEPS - 1);

  ts_state_e         r_state;
  logic              r_pending;
  logic              r_tick;
  logic              r_done;
  logic              r_running;
  logic              r_overrun;
  logic [STEP_W-1:0] r_idx;
  logic [STEP_W-1:0] r_next_idx;

  logic w_rise;
  logic w_req;
  logic w_last;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_slow_edge (
    .clk    (clk_in),
    .rst_n  (rst_n),
    .d_async(clk_slow),
    .rise   (w_rise)
  );

  assign w_req  = w_rise | r_pending;
  assign w_last = (r_next_idx == LAST_IDX);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TS_IDLE;
      r_pending  <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_running  <= 1'b0;
      r_overrun  <= 1'b0;
      r_idx      <= '0;
      r_next_idx <= '0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (abort) begin
        r_state   <= TS_IDLE;
        r_pending <= 1'b0;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          TS_IDLE: begin
            if (start) begin
              r_state    <= TS_RUN;
              r_running  <= 1'b1;
              r_idx      <= '0;
              r_next_idx <= '0;
              r_pending  <= 1'b0;
              r_overrun  <= 1'b0;
            end
          end
          TS_RUN: begin
            if (w_req) begin
              if (!net_busy) begin
                r_tick     <= 1'b1;
                r_idx      <= r_next_idx;
                r_next_idx <= r_next_idx + 1'b1;
                r_pending  <= 1'b0;
                if (w_last) r_state <= TS_DRAIN;
              end else begin
                // Only one tick can wait; a second edge while one is queued is lost.
                r_pending <= 1'b1;
                if (w_rise && r_pending) r_overrun <= 1'b1;
              end
            end
          end
          TS_DRAIN: begin
            if (!net_busy) begin
              r_state   <= TS_DONE;
              r_done    <= 1'b1;
              r_running <= 1'b0;
            end
          end
          TS_DONE: begin
            r_state <= TS_IDLE;
          end
          default: begin
            r_state   <= TS_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign step_tick = r_tick;
  assign step_idx  = r_idx;
  assign running   = r_running;
  assign done      = r_done;
  assign overrun   = r_overrun;

endmodule
